// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the AXI-lite seven-segment multiplexer.
// Holds the hex decode table, the blank pattern and the bus FSM states.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Segment order is a..g from MSB to LSB; a 0 lights the segment.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevseg_scan.sv
// Display scanner: refresh counter, digit rotation, anode select and decode.
// Outputs are registered one cycle behind the scan index.
module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_DIGITS*4-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   lit_mask_i,
  output logic [6:0]              sev_seg_o,
  output logic [NUM_DIGITS-1:0]   anode_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            digit_sel;
  logic                  lit;
  logic                  cnt_wrap;

  assign cnt_wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // A masked-off digit keeps its time slot but drives nothing.
  always_comb begin
    digit_sel = '0;
    lit       = 1'b0;
    anode_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        digit_sel = digits_i[i*4 +: 4];
        lit       = lit_mask_i[i];
        if (lit_mask_i[i]) begin
          anode_d[i] = 1'b0;
        end
      end
    end
    seg_d = lit ? hex2seg(digit_sel) : SEG_BLANK;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign sev_seg_o = seg_q;
  assign anode_o   = anode_q;

endmodule

// File: rtl/axil_sevseg_mux.sv
// AXI-lite-style slave storing one hex nibble per digit, multiplexed onto a display.
// Define SEVSEG_BLANK_EN to add a per-digit enable mask at address NUM_DIGITS.
module axil_sevseg_mux
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int ADDR_W      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_W-1:0]     aw_addr,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [3:0]            w_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_W-1:0]     ar_addr,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [3:0]            r_data,
  output logic [6:0]            sev_seg,
  output logic [NUM_DIGITS-1:0] anode
);

  wr_state_e               wr_state_q;
  rd_state_e               rd_state_q;
  logic                    aw_ready_q, w_ready_q, b_valid_q;
  logic                    ar_ready_q, r_valid_q;
  logic [3:0]              r_data_q;
  logic [ADDR_W-1:0]       awaddr_q;
  logic [3:0]              wdata_q;
  logic [NUM_DIGITS*4-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   lit_mask;

  logic                    aw_hs, w_hs, wr_commit;
  logic [ADDR_W-1:0]       wr_addr;
  logic [3:0]              wr_data;
  logic [3:0]              rd_lookup;

`ifdef SEVSEG_BLANK_EN
  localparam int MW = (NUM_DIGITS < 4) ? NUM_DIGITS : 4;
  localparam logic [ADDR_W-1:0] MASK_ADDR = ADDR_W'(NUM_DIGITS);
  logic [NUM_DIGITS-1:0] mask_q;
  assign lit_mask = mask_q;
`else
  assign lit_mask = '1;
`endif

  assign aw_hs = aw_valid && aw_ready_q;
  assign w_hs  = w_valid && w_ready_q;

  // A channel whose ready is already low was captured earlier in W_IDLE.
  assign wr_addr   = aw_ready_q ? aw_addr : awaddr_q;
  assign wr_data   = w_ready_q ? w_data : wdata_q;
  assign wr_commit = (wr_state_q == W_IDLE) && (aw_hs || !aw_ready_q) && (w_hs || !w_ready_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b1;
      b_valid_q  <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      digits_q   <= '0;
`ifdef SEVSEG_BLANK_EN
      mask_q     <= '1;
`endif
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_ready_q <= 1'b0;
            awaddr_q   <= aw_addr;
          end
          if (w_hs) begin
            w_ready_q <= 1'b0;
            wdata_q   <= w_data;
          end
          if (wr_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (wr_addr == ADDR_W'(i)) begin
                digits_q[i*4 +: 4] <= wr_data;
              end
            end
`ifdef SEVSEG_BLANK_EN
            if (wr_addr == MASK_ADDR) begin
              mask_q[MW-1:0] <= wr_data[MW-1:0];
            end
`endif
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b1;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample the registers before any same-edge write lands.
  always_comb begin
    rd_lookup = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ar_addr == ADDR_W'(i)) begin
        rd_lookup = digits_q[i*4 +: 4];
      end
    end
`ifdef SEVSEG_BLANK_EN
    if (ar_addr == MASK_ADDR) begin
      rd_lookup = 4'(mask_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_valid && ar_ready_q) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b1;
            r_data_q   <= rd_lookup;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready) begin
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;

  sevseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk_i     (clk),
    .rst_i     (rst),
    .digits_i  (digits_q),
    .lit_mask_i(lit_mask),
    .sev_seg_o (sev_seg),
    .anode_o   (anode)
  );

endmodule

// File: doc/axil_sevseg_mux.md
Name: axil_sevseg_mux

Overview:
- Multi-digit successor to the single-digit seven-segment display path.
- A bus master writes one hex nibble per digit through an AXI-lite-style write/read slave.
- The block stores the nibbles and time-multiplexes them onto a shared active-low segment bus and an active-low one-hot anode bus.
- Sits between the AXI-lite master and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes (2..8).
- ADDR_W, 3, address width; must satisfy 2**ADDR_W > NUM_DIGITS.
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address accepted.
- aw_addr  in  ADDR_W  digit index to write.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data accepted.
- w_data  in  4  hex nibble.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response accepted.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address accepted.
- ar_addr  in  ADDR_W  digit index to read.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data accepted.
- r_data  out  4  stored nibble.
- sev_seg  out  7  segments a..g MSB-first, active-low.
- anode  out  NUM_DIGITS  digit select, active-low one-hot.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Digit registers cleared to 0; scan index and refresh counter cleared to 0.
  - aw_ready=1, w_ready=1, ar_ready=1; b_valid=0, r_valid=0, r_data=0.
  - anode all ones; sev_seg=7'b1111111.
  - Reset mid-transaction abandons it; no response is issued.
- Write FSM, states W_IDLE, W_RESP:
  - aw and w channels are captured independently; each ready drops after its own handshake.
  - Once both are captured, the digit register updates at that edge and the FSM enters W_RESP with b_valid=1.
  - b_valid holds until b_ready=1. On that handshake: b_valid=0, aw_ready=w_ready=1, FSM returns to W_IDLE.
  - Simultaneous aw and w handshake in one cycle: update plus b_valid=1 on the next edge (1-cycle latency).
  - aw_addr>=NUM_DIGITS: no register changes, but the write response is still issued.
- Read FSM, states R_IDLE, R_DATA:
  - ar handshake: ar_ready=0, r_valid=1, r_data=register value, all on the next edge.
  - Out-of-range address returns r_data=0.
  - r_valid and r_data hold until r_ready=1, then r_valid=0 and ar_ready=1.
- Read and write FSMs are independent. A read of the address being written in the same cycle returns the old value.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the scan index advances by 1; NUM_DIGITS-1 wraps to 0.
  - anode and sev_seg are registered. They reflect the new index and that digit's stored value one cycle after the index changes.
  - First digit lights on the first cycle after reset release (index 0).
- Decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
- A write to the currently displayed digit appears on sev_seg one cycle after the register updates.

Optional Feature:
- Macro SEVSEG_BLANK_EN.
- Defined:
  - Address NUM_DIGITS is a NUM_DIGITS-bit enable mask. It is writable using the low w_data bits and readable; bits above 4 are unreachable when NUM_DIGITS>4 and stay set.
  - Mask resets to all ones.
  - A digit whose mask bit is 0 drives sev_seg=7'b1111111 and anode all ones during its slot. The scan timing is unchanged.
- Undefined: address NUM_DIGITS is out-of-range, and all digits are always lit.

Decomposition:
- Package sevseg_pkg holds:
  - the hex-to-segment function;
  - SEG_BLANK=7'b1111111;
  - the write/read FSM state enums.
- One sub-module, sevseg_scan: refresh counter, index rotation, anode generation, decode and output registers.
- Bus FSMs and digit storage live in the top.

Test Plan (bench uses NUM_DIGITS=4, REFRESH_DIV=4):
- Reset, then idle 20 cycles -> each digit slot is 4 cycles; anode goes 1110,1101,1011,0111,1110; sev_seg=0000001 in every slot.
- Write addr 2, data 0xA with aw and w in the same cycle -> b_valid on the next edge; the anode=1011 slot shows 0001000.
- w_valid 3 cycles before aw_valid, with b_ready held low for 5 cycles -> w_ready drops after w handshake; b_valid stays high until b_ready; no second write.
- Write addr 5 (0xF), then read addr 5 -> b_valid still asserted; r_data=0; digits unchanged.
- Read addr 2 after the 0xA write with r_ready delayed 3 cycles -> r_valid and r_data=0xA stable until the handshake.
- Assert rst low mid-write during W_RESP -> b_valid=0, all digits 0, anode=1111 and sev_seg=1111111 on the next edge. With SEVSEG_BLANK_EN, write mask 0b0101 -> slots 1 and 3 blank.
